data_access_unit: RTL and testbench

DATA_ACCESS_UNIT -- requirements
Module: data_access_unit

---
 rtl/data_access_pkg.sv | 20 ++
 rtl/data_access_unit_if.sv | 30 +++
 rtl/data_access_unit_ram.sv | 32 +++
 rtl/data_access_unit.sv | 67 ++++++
 tb/tb_data_access_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/data_access_pkg.sv
// Shared constants for the data access unit: datapath width, I/O window base
// and ALU opcode encoding.
package data_access_pkg;

  localparam int          DATA_W      = 16;
  localparam int          MEM_DEPTH   = 256;
  localparam logic [15:0] IO_BASE_DEF = 16'hFF00;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOT = 3'b010,
    ALU_SHL = 3'b011,
    ALU_SHR = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

endpackage

// File: rtl/data_access_unit_if.sv
// Load/store and I/O bus between the core-side requester and the data access unit.
interface data_access_unit_if #(
  parameter int W = 16
);
  // Enables are level strobes qualified by the current address: a store
  // lands on the rising edge where data_write_en is high, a load is
  // combinational while data_read_en is high. No back-pressure exists.
  logic         data_read_en;
  logic         data_write_en;
  logic [W-1:0] data_write_value;
  logic [W-1:0] data_read_value;
  logic [W-1:0] io_address;
  logic [W-1:0] io_write_value;
  logic [W-1:0] io_read_value;
  logic         io_read_en;
  logic         io_write_en;
  logic         is_io;

  modport slave (
    input  data_read_en, data_write_en, data_write_value, io_read_value,
    output data_read_value, io_address, io_write_value, io_read_en,
           io_write_en, is_io
  );

  modport master (
    output data_read_en, data_write_en, data_write_value, io_read_value,
    input  data_read_value, io_address, io_write_value, io_read_en,
           io_write_en, is_io
  );
endinterface

// File: rtl/data_access_unit_ram.sv
// Word RAM with synchronous write, combinational gated read and an
// asynchronous clear of every word while reset is held.
module data_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Reads see the pre-edge word, so read-during-write returns old data.
  assign rdata_o = re_i ? mem_q[addr_i] : '0;

endmodule

// File: rtl/data_access_unit.sv
// ALU plus address decoder steering loads/stores to the internal RAM or to
// the external I/O bus when the ALU result falls in the I/O window.
module data_access_unit
  import data_access_pkg::*;
#(
  parameter int          DATA_W    = data_access_pkg::DATA_W,
  parameter int          MEM_DEPTH = data_access_pkg::MEM_DEPTH,
  parameter logic [15:0] IO_BASE   = IO_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  data_access_unit_if.slave bus
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] ram_rdata;
  logic              ram_re;
  logic              ram_we;

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(alu_op))
      ALU_ADD: alu_result = a + b;
      ALU_SUB: alu_result = a - b;
      ALU_NOT: alu_result = ~a;
      ALU_SHL: alu_result = a << b[3:0];
      ALU_SHR: alu_result = a >> b[3:0];
      ALU_AND: alu_result = a & b;
      ALU_OR:  alu_result = a | b;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  assign bus.is_io          = (alu_result >= DATA_W'(IO_BASE));
  assign bus.io_address     = alu_result;
  assign bus.io_write_value = bus.data_write_value;
  assign bus.io_read_en     = bus.data_read_en  &  bus.is_io;
  assign bus.io_write_en    = bus.data_write_en &  bus.is_io;
  assign ram_re             = bus.data_read_en  & ~bus.is_io;
  assign ram_we             = bus.data_write_en & ~bus.is_io;

  assign bus.data_read_value = bus.is_io ? bus.io_read_value : ram_rdata;

  // Upper address bits below the I/O window are ignored, so RAM aliases.
  data_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (alu_result[AW-1:0]),
    .wdata_i (bus.data_write_value),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_data_access_unit.sv
// Directed bench for data_access_unit: ALU sweep, decode boundaries,
// RAM store/load, read-during-write and reset clearing.
module tb_data_access_unit;
  import data_access_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        zero;

  int n_tests;
  int n_fail;

  data_access_unit_if #(.W(16)) bus ();

  data_access_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .zero       (zero),
    .bus        (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_alu(input logic [15:0] aa, input logic [15:0] bb, input logic [2:0] op);
    a = aa; b = bb; alu_op = op;
    #1;
  endtask

  task automatic set_bus(input logic re, input logic we, input logic [15:0] wv, input logic [15:0] iov);
    bus.data_read_en     = re;
    bus.data_write_en    = we;
    bus.data_write_value = wv;
    bus.io_read_value    = iov;
    #1;
  endtask

  // store at address (a+b) on the next rising edge, leave bus idle afterwards
  task automatic store(input logic [15:0] addr, input logic [15:0] val);
    @(negedge clk);
    set_alu(addr, 16'h0000, ALU_ADD);
    set_bus(1'b0, 1'b1, val, 16'h0000);
    @(negedge clk);
    set_bus(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic load_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    set_alu(addr, 16'h0000, ALU_ADD);
    set_bus(1'b1, 1'b0, 16'h0000, 16'h0000);
    check(tag, bus.data_read_value, exp);
    set_bus(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] exp;
  } alu_vec_t;

  alu_vec_t alu_vecs[$];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    a = '0; b = '0; alu_op = '0;
    bus.data_read_en = 1'b0; bus.data_write_en = 1'b0;
    bus.data_write_value = '0; bus.io_read_value = '0;

    // Combinational paths stay live during reset
    #2;
    set_alu(16'h0005, 16'h0003, ALU_ADD);
    check("alu_in_reset", alu_result, 16'h0008);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    load_check("reset_ram0", 16'h0000, 16'h0000);
    load_check("reset_ram_ff", 16'h00FF, 16'h0000);

    alu_vecs = '{
      '{16'h0005, 16'h0003, 3'b000, 16'h0008},
      '{16'h0005, 16'h0003, 3'b001, 16'h0002},
      '{16'h0005, 16'h0003, 3'b010, 16'hFFFA},
      '{16'h0005, 16'h0003, 3'b011, 16'h0028},
      '{16'h0005, 16'h0003, 3'b100, 16'h0000},
      '{16'h0005, 16'h0003, 3'b101, 16'h0001},
      '{16'h0005, 16'h0003, 3'b110, 16'h0007},
      '{16'h0005, 16'h0003, 3'b111, 16'h0000},
      '{16'hFFFF, 16'h0001, 3'b111, 16'h0001},
      '{16'h8000, 16'h0013, 3'b100, 16'h1000},
      '{16'h0001, 16'h001F, 3'b011, 16'h8000},
      '{16'h7FFF, 16'h8000, 3'b111, 16'h0000},
      '{16'h1234, 16'h1234, 3'b001, 16'h0000},
      '{16'hFFFF, 16'h0001, 3'b000, 16'h0000}
    };
    foreach (alu_vecs[i]) begin
      set_alu(alu_vecs[i].a, alu_vecs[i].b, alu_vecs[i].op);
      check($sformatf("alu_%0d", i), alu_result, alu_vecs[i].exp);
      check($sformatf("zero_%0d", i), zero, (alu_vecs[i].exp == 16'h0000));
    end

    // RAM store/load at 0x0010 formed as 000A + 0006
    @(negedge clk);
    set_alu(16'h000A, 16'h0006, ALU_ADD);
    set_bus(1'b0, 1'b1, 16'hBEEF, 16'h0000);
    check("ram_addr", alu_result, 16'h0010);
    check("ram_wr_no_io", {bus.io_write_en, bus.is_io}, 2'b00);
    @(negedge clk);
    set_bus(1'b1, 1'b0, 16'h0000, 16'h0000);
    check("ram_load", bus.data_read_value, 16'hBEEF);
    check("ram_load_strobes", {bus.io_read_en, bus.io_write_en}, 2'b00);
    set_bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("ram_read_off", bus.data_read_value, 16'h0000);

    // Read during write at the same address: old word before edge, new after
    set_bus(1'b1, 1'b1, 16'h1111, 16'h0000);
    check("rdw_old", bus.data_read_value, 16'hBEEF);
    @(posedge clk);
    #1;
    check("rdw_new", bus.data_read_value, 16'h1111);
    @(negedge clk);
    set_bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    load_check("alias_0110", 16'h0110, 16'h1111);

    // I/O decode and strobes at FF02
    @(negedge clk);
    set_alu(16'hFF00, 16'h0002, ALU_ADD);
    set_bus(1'b0, 1'b1, 16'h7777, 16'h0000);
    check("io_wr_strobes", {bus.is_io, bus.io_write_en, bus.io_read_en}, 3'b110);
    check("io_address", bus.io_address, 16'hFF02);
    check("io_write_value", bus.io_write_value, 16'h7777);
    @(negedge clk);
    set_bus(1'b1, 1'b0, 16'h0000, 16'h1357);
    check("io_read_value", bus.data_read_value, 16'h1357);
    check("io_rd_strobes", {bus.io_read_en, bus.io_write_en}, 2'b10);
    set_bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    load_check("io_no_ram_wr", 16'h0002, 16'h0000);

    set_alu(16'hFEFF, 16'h0000, ALU_ADD);
    check("is_io_feff", bus.is_io, 1'b0);
    set_alu(16'hFF00, 16'h0000, ALU_ADD);
    check("is_io_ff00", bus.is_io, 1'b1);
    set_alu(16'hFFFF, 16'h0000, ALU_ADD);
    check("is_io_ffff", bus.is_io, 1'b1);
    set_bus(1'b0, 1'b1, 16'hAAAA, 16'h0000);
    @(negedge clk);
    set_bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    load_check("io_ffff_no_ram", 16'h00FF, 16'h0000);

    // Reset clears RAM asynchronously and blocks writes
    store(16'h0003, 16'hA5A5);
    load_check("pre_reset", 16'h0003, 16'hA5A5);
    #2;
    rst_n = 1'b0;
    #1;
    load_check("reset_clear", 16'h0003, 16'h0000);
    load_check("reset_clear_10", 16'h0010, 16'h0000);
    set_alu(16'h0003, 16'h0000, ALU_ADD);
    set_bus(1'b0, 1'b1, 16'h5A5A, 16'h0000);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    set_bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    load_check("reset_blocks_wr", 16'h0003, 16'h0000);

    // First edge after release accepts a write
    store(16'h0003, 16'h0F0F);
    load_check("post_reset_wr", 16'h0003, 16'h0F0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
